ptwalker: RTL and testbench

- Hardware page-table walker that services translation misses raised by a TLB.
- On a miss it reads page-table entries through a single-outstanding memory port.
- It then either writes the leaf PTE and page type into the TLB or signals a page or access fault.
- It sits between one TLB (the ITLB or DTLB) and the data-side memory arbiter.

---
 rtl/ptwalker_pkg.sv | 42 ++++
 rtl/ptwalker_ptecheck.sv | 46 ++++
 rtl/ptwalker.sv | 192 +++++++++++++++++++
 tb/tb_ptwalker.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ptwalker_pkg.sv
// Shared walker types: FSM states, PTE bit positions, SATP modes, level helpers.
// Purely declarative, no timing; the UPDATE state exists only when PTWALKER_ADUPDATE_EN is defined.
package ptwalker_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
`ifdef PTWALKER_ADUPDATE_EN
        S_UPDATE,
`endif
        S_LEAF,
        S_FAULT
    } state_t;

    localparam int PTE_V       = 0;
    localparam int PTE_R       = 1;
    localparam int PTE_W       = 2;
    localparam int PTE_X       = 3;
    localparam int PTE_U       = 4;
    localparam int PTE_G       = 5;
    localparam int PTE_A       = 6;
    localparam int PTE_D       = 7;
    localparam int PTE_PPN_LSB = 10;

    localparam logic [3:0] MODE_SV32 = 4'd1;
    localparam logic [3:0] MODE_SV39 = 4'd8;
    localparam logic [3:0] MODE_SV48 = 4'd9;

    function automatic int vpn_seg(input int xlen);
        return (xlen == 32) ? 10 : 9;
    endfunction

    function automatic logic [1:0] top_level(input logic [3:0] mode);
        if (mode == MODE_SV48)
            return 2'd3;
        else if (mode == MODE_SV39)
            return 2'd2;
        else
            return 2'd1;
    endfunction

endpackage

// File: rtl/ptwalker_ptecheck.sv
// Combinational PTE classifier: malformed entry, leaf, bad pointer flags, misaligned superpage.
// Zero latency, no handshake.
module ptwalker_ptecheck
    import ptwalker_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int PPN_BITS = 44
) (
    input  logic [XLEN-1:0] pte,
    input  logic [1:0]      level,
    output logic            pte_bad,
    output logic            pte_leaf,
    output logic            ptr_bad,
    output logic            misaligned
);

    localparam int SEG = vpn_seg(XLEN);
    localparam int CHK = (XLEN == 32) ? SEG : 3 * SEG;

    logic [PPN_BITS-1:0] ppn;
    logic                rsvd;
    logic                unused_bits;

    assign ppn         = pte[PTE_PPN_LSB +: PPN_BITS];
    assign unused_bits = ^{pte[9:8], pte[PTE_G]};

    // Bits above the PPN field must be zero on RV64.
    if (XLEN > PTE_PPN_LSB + PPN_BITS) begin : g_rsvd
        assign rsvd = |pte[XLEN-1:PTE_PPN_LSB+PPN_BITS];
    end else begin : g_norsvd
        assign rsvd = 1'b0;
    end

    assign pte_bad  = !pte[PTE_V] || (!pte[PTE_R] && pte[PTE_W]) || rsvd;
    assign pte_leaf = pte[PTE_R] || pte[PTE_X];
    assign ptr_bad  = pte[PTE_D] || pte[PTE_A] || pte[PTE_U];

    always_comb begin
        misaligned = 1'b0;
        for (int i = 0; i < CHK; i++) begin
            if (i < int'(level) * SEG && ppn[i])
                misaligned = 1'b1;
        end
    end

endmodule

// File: rtl/ptwalker.sv
// Page-table walker: first MemReq the cycle after TLBMiss accept, TLBWrite/fault the cycle after the last MemAck.
// Single outstanding request held until MemAck, even across TLBFlush; PTWALKER_ADUPDATE_EN adds the A/D write-back.
module ptwalker
    import ptwalker_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int PA_BITS     = 56,
    parameter int PPN_BITS    = 44,
    parameter int SVMODE_BITS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SVMODE_BITS-1:0] SATP_MODE,
    input  logic [PPN_BITS-1:0]    SATP_PPN,
    input  logic [XLEN-1:0]        VAdr,
    input  logic                   WriteAccess,
    input  logic                   TLBMiss,
    input  logic                   TLBFlush,
    output logic                   MemReq,
    output logic [PA_BITS-1:0]     MemAdr,
    output logic                   MemWrite,
    output logic [XLEN-1:0]        MemWriteData,
    input  logic                   MemAck,
    input  logic [XLEN-1:0]        MemReadData,
    input  logic                   MemAccessFault,
    output logic [XLEN-1:0]        PTE,
    output logic [1:0]             PageTypeWriteVal,
    output logic                   TLBWrite,
    output logic                   WalkerPageFault,
    output logic                   WalkerAccessFault,
    output logic                   WalkerBusy
);

    localparam int SEG       = vpn_seg(XLEN);
    localparam int PTE_SHIFT = (XLEN == 32) ? 2 : 3;

    state_t             state, state_d;
    logic [1:0]         level, level_d, start_lvl;
    logic [XLEN-1:0]    vadr_q, vadr_d, pte_q, pte_d;
    logic [PA_BITS-1:0] adr_q, adr_d;
    logic [1:0]         ptype_q, ptype_d;
    logic               facc_q, facc_d, abort_q, abort;
    logic               pte_bad, pte_leaf, ptr_bad, misaligned;
`ifdef PTWALKER_ADUPDATE_EN
    logic               wr_q, wr_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;
`else
    logic               unused_write_access;
    assign unused_write_access = WriteAccess;
`endif

    function automatic logic [PA_BITS-1:0] pte_addr(input logic [PPN_BITS-1:0] ppn,
                                                    input logic [XLEN-1:0] va,
                                                    input logic [1:0] lvl);
        logic [SEG-1:0] vpn;
        vpn = SEG'(va >> (12 + SEG * int'(lvl)));
        return PA_BITS'({ppn, 12'b0}) + (PA_BITS'(vpn) << PTE_SHIFT);
    endfunction

    ptwalker_ptecheck #(.XLEN(XLEN), .PPN_BITS(PPN_BITS)) u_ptecheck (
        .pte        (MemReadData),
        .level      (level),
        .pte_bad    (pte_bad),
        .pte_leaf   (pte_leaf),
        .ptr_bad    (ptr_bad),
        .misaligned (misaligned)
    );

    assign start_lvl = top_level(4'(SATP_MODE));
    // A flush seen in the same cycle as a completion already counts as an abort.
    assign abort     = abort_q || TLBFlush;

    always_comb begin
        state_d = state;
        level_d = level;
        vadr_d  = vadr_q;
        pte_d   = pte_q;
        adr_d   = adr_q;
        ptype_d = ptype_q;
        facc_d  = facc_q;
`ifdef PTWALKER_ADUPDATE_EN
        wr_d    = wr_q;
        wdata_d = wdata_q;
`endif
        case (state)
            S_IDLE: begin
                if (TLBMiss && !TLBFlush) begin
                    vadr_d  = VAdr;
                    level_d = start_lvl;
                    adr_d   = pte_addr(SATP_PPN, VAdr, start_lvl);
                    state_d = S_READ;
`ifdef PTWALKER_ADUPDATE_EN
                    wr_d    = WriteAccess;
`endif
                end
            end
            S_READ: begin
                if (MemAck) begin
                    if (abort) begin
                        state_d = S_IDLE;
                    end else if (MemAccessFault) begin
                        facc_d  = 1'b1;
                        state_d = S_FAULT;
                    end else if (pte_bad || (pte_leaf && misaligned) ||
                                 (!pte_leaf && (level == 2'd0 || ptr_bad))) begin
                        facc_d  = 1'b0;
                        state_d = S_FAULT;
                    end else if (pte_leaf) begin
                        pte_d   = MemReadData;
                        ptype_d = level;
                        state_d = S_LEAF;
`ifdef PTWALKER_ADUPDATE_EN
                        if (!MemReadData[PTE_A] || (!MemReadData[PTE_D] && wr_q)) begin
                            wdata_d = MemReadData;
                            wdata_d[PTE_A] = 1'b1;
                            wdata_d[PTE_D] = MemReadData[PTE_D] || wr_q;
                            state_d = S_UPDATE;
                        end
`endif
                    end else begin
                        level_d = level - 2'd1;
                        adr_d   = pte_addr(MemReadData[PTE_PPN_LSB +: PPN_BITS], vadr_q, level - 2'd1);
                    end
                end
            end
`ifdef PTWALKER_ADUPDATE_EN
            S_UPDATE: begin
                if (MemAck) begin
                    if (abort) begin
                        state_d = S_IDLE;
                    end else if (MemAccessFault) begin
                        facc_d  = 1'b1;
                        state_d = S_FAULT;
                    end else begin
                        pte_d   = wdata_q;
                        state_d = S_LEAF;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            level   <= '0;
            vadr_q  <= '0;
            pte_q   <= '0;
            adr_q   <= '0;
            ptype_q <= '0;
            facc_q  <= 1'b0;
            abort_q <= 1'b0;
`ifdef PTWALKER_ADUPDATE_EN
            wr_q    <= 1'b0;
            wdata_q <= '0;
`endif
        end else begin
            state   <= state_d;
            level   <= level_d;
            vadr_q  <= vadr_d;
            pte_q   <= pte_d;
            adr_q   <= adr_d;
            ptype_q <= ptype_d;
            facc_q  <= facc_d;
            abort_q <= (state_d != S_IDLE) && abort;
`ifdef PTWALKER_ADUPDATE_EN
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
`endif
        end
    end

`ifdef PTWALKER_ADUPDATE_EN
    assign MemReq       = (state == S_READ) || (state == S_UPDATE);
    assign MemWrite     = (state == S_UPDATE);
    assign MemWriteData = wdata_q;
`else
    assign MemReq       = (state == S_READ);
    assign MemWrite     = 1'b0;
    assign MemWriteData = '0;
`endif
    assign MemAdr            = adr_q;
    assign PTE               = pte_q;
    assign PageTypeWriteVal  = ptype_q;
    assign TLBWrite          = (state == S_LEAF) && !abort;
    assign WalkerPageFault   = (state == S_FAULT) && !facc_q && !abort;
    assign WalkerAccessFault = (state == S_FAULT) && facc_q && !abort;
    assign WalkerBusy        = (state != S_IDLE);

endmodule

// File: tb/tb_ptwalker.sv
// Directed bench for ptwalker: an Sv39/Sv48-capable instance and an Sv32 instance share clock and reset.
// Outputs are sampled on the falling edge; inputs change right after it.
module tb_ptwalker;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // RV64 instance
    logic [3:0]  satp_mode;
    logic [43:0] satp_ppn;
    logic [63:0] vadr, rdata, wdata, pte;
    logic        wr, miss, flush, ack, af;
    logic        req, mwr, tlbw, pf, afo, busy;
    logic [55:0] madr;
    logic [1:0]  ptype;

    // RV32 instance
    logic [0:0]  s_mode;
    logic [21:0] s_ppn;
    logic [31:0] s_vadr, s_rdata, s_wdata, s_pte;
    logic        s_wr, s_miss, s_flush, s_ack, s_af;
    logic        s_req, s_mwr, s_tlbw, s_pf, s_afo, s_busy;
    logic [33:0] s_madr;
    logic [1:0]  s_ptype;

    ptwalker u64 (
        .clk(clk), .reset(reset), .SATP_MODE(satp_mode), .SATP_PPN(satp_ppn),
        .VAdr(vadr), .WriteAccess(wr), .TLBMiss(miss), .TLBFlush(flush),
        .MemReq(req), .MemAdr(madr), .MemWrite(mwr), .MemWriteData(wdata),
        .MemAck(ack), .MemReadData(rdata), .MemAccessFault(af),
        .PTE(pte), .PageTypeWriteVal(ptype), .TLBWrite(tlbw),
        .WalkerPageFault(pf), .WalkerAccessFault(afo), .WalkerBusy(busy)
    );

    ptwalker #(.XLEN(32), .PA_BITS(34), .PPN_BITS(22), .SVMODE_BITS(1)) u32 (
        .clk(clk), .reset(reset), .SATP_MODE(s_mode), .SATP_PPN(s_ppn),
        .VAdr(s_vadr), .WriteAccess(s_wr), .TLBMiss(s_miss), .TLBFlush(s_flush),
        .MemReq(s_req), .MemAdr(s_madr), .MemWrite(s_mwr), .MemWriteData(s_wdata),
        .MemAck(s_ack), .MemReadData(s_rdata), .MemAccessFault(s_af),
        .PTE(s_pte), .PageTypeWriteVal(s_ptype), .TLBWrite(s_tlbw),
        .WalkerPageFault(s_pf), .WalkerAccessFault(s_afo), .WalkerBusy(s_busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic start64(input logic [63:0] va, input logic w);
        vadr = va;
        wr   = w;
        miss = 1'b1;
        @(negedge clk);
        miss = 1'b0;
    endtask

    // Waits (bounded) for a read request, checks it, and completes it with one MemAck.
    task automatic serve64(input string tag, input logic [55:0] exp_adr,
                           input logic [63:0] d, input logic f);
        for (int i = 0; i < 20 && !req; i++) @(negedge clk);
        chk({tag, "_req"}, 64'(req), 64'd1);
        chk({tag, "_adr"}, 64'(madr), 64'(exp_adr));
        chk({tag, "_we"}, 64'(mwr), 64'd0);
        rdata = d;
        af    = f;
        ack   = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        af  = 1'b0;
    endtask

    // Checks the completion cycle's strobes, then that everything is quiet one cycle later.
    task automatic expect_end(input string tag, input logic t, input logic p, input logic a);
        chk({tag, "_tlbw"}, 64'(tlbw), 64'(t));
        chk({tag, "_pf"}, 64'(pf), 64'(p));
        chk({tag, "_af"}, 64'(afo), 64'(a));
        @(negedge clk);
        chk({tag, "_idle"}, 64'({tlbw, pf, afo, busy, req}), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        satp_mode = 4'd8; satp_ppn = 44'h80000; vadr = '0; wr = 1'b0;
        miss = 1'b0; flush = 1'b0; ack = 1'b0; rdata = '0; af = 1'b0;
        s_mode = 1'b1; s_ppn = 22'h80000; s_vadr = '0; s_wr = 1'b0;
        s_miss = 1'b0; s_flush = 1'b0; s_ack = 1'b0; s_rdata = '0; s_af = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_ctrl", 64'({req, mwr, tlbw, pf, afo, busy}), 64'd0);
        chk("rst_adr", 64'(madr), 64'd0);
        chk("rst_pte", pte, 64'd0);
        chk("rst_wdata", wdata, 64'd0);
        chk("rst_ptype", 64'(ptype), 64'd0);
        chk("rst32_ctrl", 64'({s_req, s_tlbw, s_busy}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Sv39 4K walk: VPN2=1, VPN1=1, VPN0=3
        start64(64'h40203000, 1'b0);
        chk("walk_first_req", 64'(req), 64'd1);
        serve64("walk_l2", 56'h80000008, 64'h20000401, 1'b0);
        serve64("walk_l1", 56'h80001008, 64'h20000801, 1'b0);
        serve64("walk_l0", 56'h80002018, 64'h20000CCF, 1'b0);
        chk("walk_pte", pte, 64'h20000CCF);
        chk("walk_ptype", 64'(ptype), 64'd0);
        expect_end("walk", 1'b1, 1'b0, 1'b0);

        // Aligned gigapage (PPN 0x80000, low 18 bits clear)
        start64(64'h40203000, 1'b0);
        serve64("giga", 56'h80000008, 64'h200000CF, 1'b0);
        chk("giga_ptype", 64'(ptype), 64'd2);
        expect_end("giga", 1'b1, 1'b0, 1'b0);

        // Misaligned gigapage (PPN 0x80001)
        start64(64'h40203000, 1'b0);
        serve64("misal", 56'h80000008, 64'h200004CF, 1'b0);
        expect_end("misal", 1'b0, 1'b1, 1'b0);

        start64(64'h40203000, 1'b0);
        serve64("inval", 56'h80000008, 64'h0, 1'b0);
        expect_end("inval", 1'b0, 1'b1, 1'b0);

        start64(64'h40203000, 1'b0);
        serve64("w_no_r", 56'h80000008, 64'h5, 1'b0);
        expect_end("w_no_r", 1'b0, 1'b1, 1'b0);

        start64(64'h40203000, 1'b0);
        serve64("acc", 56'h80000008, 64'h20000CCF, 1'b1);
        expect_end("acc", 1'b0, 1'b0, 1'b1);

        // Flush in the second READ cycle, MemAck three cycles later
        start64(64'h40203000, 1'b0);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_hold1", 64'(req), 64'd1);
        @(negedge clk);
        chk("fl_hold2", 64'(req), 64'd1);
        @(negedge clk);
        chk("fl_hold3", 64'({req, madr}), {7'd0, 1'b1, 56'h80000008});
        rdata = 64'h200000CF;
        ack   = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("fl_quiet1", 64'({tlbw, pf, afo, busy, req}), 64'd0);
        @(negedge clk);
        chk("fl_quiet2", 64'({tlbw, pf, afo, busy, req}), 64'd0);

        // Flush arriving in the LEAF cycle suppresses that strobe
        start64(64'h40203000, 1'b0);
        serve64("flleaf", 56'h80000008, 64'h200000CF, 1'b0);
        flush = 1'b1;
        #1;
        chk("flleaf_tlbw", 64'(tlbw), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("flleaf_idle", 64'({tlbw, busy}), 64'd0);

        // Reset mid-walk drops MemReq
        start64(64'h40203000, 1'b0);
        chk("rstw_req", 64'(req), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rstw_drop", 64'({req, busy, tlbw, pf, afo}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Sv32 megapage: root 0x80000<<12, VPN1=1, 4-byte PTEs
        s_vadr = 32'h00401000;
        s_miss = 1'b1;
        @(negedge clk);
        s_miss = 1'b0;
        chk("sv32_req", 64'(s_req), 64'd1);
        chk("sv32_adr", 64'(s_madr), 64'h080000004);
        s_rdata = 32'h200000CF;
        s_ack   = 1'b1;
        @(negedge clk);
        s_ack = 1'b0;
        chk("sv32_tlbw", 64'(s_tlbw), 64'd1);
        chk("sv32_ptype", 64'(s_ptype), 64'd1);
        chk("sv32_pte", 64'(s_pte), 64'h200000CF);
        @(negedge clk);
        chk("sv32_idle", 64'({s_tlbw, s_busy, s_pf, s_afo}), 64'd0);

        // Leaf with A=0, D=0 on a read access
        start64(64'h40203000, 1'b0);
        serve64("ad_l2", 56'h80000008, 64'h20000401, 1'b0);
        serve64("ad_l1", 56'h80001008, 64'h20000801, 1'b0);
        serve64("ad_l0", 56'h80002018, 64'h20000C0F, 1'b0);
`ifdef PTWALKER_ADUPDATE_EN
        chk("ad_no_early_tlbw", 64'(tlbw), 64'd0);
        chk("ad_wr_req", 64'({req, mwr}), 64'd3);
        chk("ad_wr_adr", 64'(madr), 64'h80002018);
        chk("ad_wr_data", wdata, 64'h20000C4F);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ad_pte", pte, 64'h20000C4F);
`else
        chk("ad_we", 64'(mwr), 64'd0);
        chk("ad_pte", pte, 64'h20000C0F);
`endif
        expect_end("ad", 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
